// File: rtl/stage_memory.sv
// ---------------------------------------------------------------------------
// stage_memory : pipeline memory stage (load/store unit)
//
// Takes one operation from the execute stage, issues a single data-memory
// request for loads/stores, waits for the acknowledge with a bounded timeout,
// and reports completion with a one-cycle done pulse. Every output is
// registered.
//
// Optional feature: define MISALIGN_CHECK_EN to reject halfword accesses at
// odd addresses and word accesses at non-word-aligned addresses. The access
// completes without a memory request and reports misaligned=1.
//
// Parameter
//   TIMEOUT     : max REQ cycles waiting for dmem_ack (1..255)
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   start       : execute stage presents an operation (honoured in IDLE only)
//   alu_result  : byte address
//   store_data  : rs2 data for stores
//   mem_read    : load operation
//   mem_write   : store operation (neither set = non-memory instruction)
//   funct3      : 000 B, 001 H, 010 W, 100 BU, 101 HU
//   dmem_req/we/addr/wdata/be : memory request, word-aligned address
//   dmem_ack/rdata            : memory response
//   busy        : stall, high in REQ and DONE
//   done        : one-cycle completion pulse
//   load_data   : extended load result
//   error       : illegal funct3 or timeout (valid with done)
//   misaligned  : misaligned access (valid with done)
// ---------------------------------------------------------------------------
module stage_memory #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        error,
  output logic        misaligned
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_lane;
  logic [2:0]       r_f3;
  logic             r_is_load;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_latch;
  logic             w_req_nxt;
  logic             w_we_nxt;
  logic [31:0]      w_addr_nxt;
  logic [31:0]      w_wdata_nxt;
  logic [3:0]       w_be_nxt;
  logic             w_done_nxt;
  logic [31:0]      w_ld_nxt;
  logic             w_err_nxt;
  logic             w_mis_nxt;

  logic             w_is_mem;
  logic             w_is_load;
  logic             w_illegal;
  logic             w_misal;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ext;
  logic             w_timeout;

  // Decode of the incoming operation; mem_read wins if both are set
  assign w_is_mem  = mem_read | mem_write;
  assign w_is_load = mem_read;
  assign w_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                     (!w_is_load && funct3[2]);

`ifdef MISALIGN_CHECK_EN
  assign w_misal = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                   ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
`else
  assign w_misal = 1'b0;
`endif

  // Byte enables and lane-replicated store data from the incoming operation
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_result[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {alu_result[1], 1'b0};
        w_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension of the returned read data
  assign w_byte = 8'(dmem_rdata >> {r_lane, 3'b000});
  assign w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = dmem_rdata;
    endcase
  end

  // Timeout fires on the REQ cycle that would bring the wait count to TIMEOUT
  assign w_timeout = (({1'b0, r_cnt} + 9'd1) == 9'(TIMEOUT));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_req_nxt   = 1'b0;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = 32'd0;
    w_wdata_nxt = 32'd0;
    w_be_nxt    = 4'd0;
    w_done_nxt  = 1'b0;
    w_ld_nxt    = load_data;
    w_err_nxt   = 1'b0;
    w_mis_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_latch = 1'b1;
          if (!w_is_mem) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else if (w_illegal) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end else if (w_misal) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            w_mis_nxt   = 1'b1;
            w_ld_nxt    = 32'd0;
          end else begin
            w_state_nxt = REQ;
            w_cnt_nxt   = '0;
            w_req_nxt   = 1'b1;
            w_we_nxt    = !w_is_load;
            w_addr_nxt  = {alu_result[31:2], 2'b00};
            w_be_nxt    = w_be;
            w_wdata_nxt = w_is_load ? 32'd0 : w_wdata;
          end
        end
      end
      REQ: begin
        if (dmem_ack) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
          if (r_is_load) w_ld_nxt = w_ext;
        end else if (w_timeout) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_ld_nxt    = 32'd0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_req_nxt   = 1'b1;
          w_we_nxt    = dmem_we;
          w_addr_nxt  = dmem_addr;
          w_be_nxt    = dmem_be;
          w_wdata_nxt = dmem_wdata;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, latched operation and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_lane     <= 2'd0;
      r_f3       <= 3'd0;
      r_is_load  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_data  <= 32'd0;
      error      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      if (w_latch) begin
        r_lane    <= alu_result[1:0];
        r_f3      <= funct3;
        r_is_load <= w_is_load;
      end
      dmem_req   <= w_req_nxt;
      dmem_we    <= w_we_nxt;
      dmem_addr  <= w_addr_nxt;
      dmem_wdata <= w_wdata_nxt;
      dmem_be    <= w_be_nxt;
      busy       <= (w_state_nxt != IDLE);
      done       <= w_done_nxt;
      load_data  <= w_ld_nxt;
      error      <= w_err_nxt;
      misaligned <= w_mis_nxt;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// ---------------------------------------------------------------------------
// tb_stage_memory : directed self-checking bench for stage_memory
// (TIMEOUT = 16). Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_stage_memory;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        error;
  logic        misaligned;

  int total;
  int bad;

  stage_memory #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .error      (error),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd);
    start      = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    alu_result = addr;
    store_data = sd;
    tick();
    start      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    mem_read = 1'b1;
    funct3 = 3'b010;
    alu_result = 32'h0000_0040;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", dmem_req); end
    total++; if (done !== 1'b0 || error !== 1'b0 || misaligned !== 1'b0)
      begin bad++; $display("FAIL reset_flags got=%b%b%b want=000", done, error, misaligned); end
    total++; if (load_data !== 32'd0 || dmem_addr !== 32'd0 || dmem_wdata !== 32'd0 || dmem_be !== 4'd0 || dmem_we !== 1'b0)
      begin bad++; $display("FAIL reset_buses got ld=%h a=%h wd=%h be=%b we=%b want zeros",
                            load_data, dmem_addr, dmem_wdata, dmem_be, dmem_we); end
    reset = 1'b0;
    start = 1'b0;
    mem_read = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
    total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL lw_req got req=%b we=%b busy=%b want 1 0 1", dmem_req, dmem_we, busy); end
    total++; if (dmem_addr !== 32'h0000_0100 || dmem_be !== 4'b1111)
      begin bad++; $display("FAIL lw_addr_be got %h/%b want 00000100/1111", dmem_addr, dmem_be); end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0;
    total++; if (done !== 1'b1 || error !== 1'b0 || dmem_req !== 1'b0)
      begin bad++; $display("FAIL lw_done got done=%b err=%b req=%b want 1 0 0", done, error, dmem_req); end
    total++; if (load_data !== 32'hDEAD_BEEF)
      begin bad++; $display("FAIL lw_data got %h want deadbeef", load_data); end
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL lw_idle got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_lb_lbu();
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0);
    total++; if (dmem_addr !== 32'h0000_0100 || dmem_be !== 4'b1000)
      begin bad++; $display("FAIL lb_addr_be got %h/%b want 00000100/1000", dmem_addr, dmem_be); end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h8011_2233;
    tick();
    dmem_ack = 1'b0;
    total++; if (load_data !== 32'hFFFF_FF80)
      begin bad++; $display("FAIL lb_data got %h want ffffff80", load_data); end
    tick();
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    total++; if (load_data !== 32'h0000_0080 || done !== 1'b1)
      begin bad++; $display("FAIL lbu_data got %h done=%b want 00000080 1", load_data, done); end
    tick();
  endtask

  task automatic test_sh();
    int busy_cycles;
    busy_cycles = 0;
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
    // cycle N+1
    if (busy) busy_cycles++;
    total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD || dmem_addr !== 32'h0000_0200)
      begin bad++; $display("FAIL sh_req got req=%b we=%b be=%b wd=%h a=%h want 1 1 1100 abcdabcd 00000200",
                            dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr); end
    // a start during REQ must be ignored
    start = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0500;
    tick();
    if (busy) busy_cycles++;
    start = 1'b0; mem_read = 1'b0;
    tick();
    if (busy) busy_cycles++;
    total++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0200 || dmem_we !== 1'b1 || dmem_be !== 4'b1100)
      begin bad++; $display("FAIL sh_stable got req=%b a=%h we=%b be=%b want 1 00000200 1 1100",
                            dmem_req, dmem_addr, dmem_we, dmem_be); end
    tick();
    if (busy) busy_cycles++;
    dmem_ack = 1'b1;
    tick();
    // cycle N+5
    if (busy) busy_cycles++;
    dmem_ack = 1'b0;
    total++; if (done !== 1'b1 || error !== 1'b0 || load_data !== 32'h0000_0080)
      begin bad++; $display("FAIL sh_done got done=%b err=%b ld=%h want 1 0 00000080", done, error, load_data); end
    tick();
    if (busy) busy_cycles++;
    total++; if (busy_cycles != 5)
      begin bad++; $display("FAIL sh_busy_cycles got %0d want 5", busy_cycles); end
  endtask

  task automatic test_timeout();
    int reqs;
    logic got;
    reqs = 0;
    got = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (done) begin got = 1'b1; break; end
      if (dmem_req) reqs++;
      tick();
    end
    total++; if (got !== 1'b1)
      begin bad++; $display("FAIL timeout_done got no done want done within 40 cycles"); end
    total++; if (reqs != 16)
      begin bad++; $display("FAIL timeout_req_cycles got %0d want 16", reqs); end
    total++; if (error !== 1'b1 || load_data !== 32'd0 || dmem_req !== 1'b0)
      begin bad++; $display("FAIL timeout_flags got err=%b ld=%h req=%b want 1 00000000 0", error, load_data, dmem_req); end
    tick();
  endtask

  task automatic test_ack_at_timeout();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    total++; if (dmem_req !== 1'b1)
      begin bad++; $display("FAIL ackto_req16 got %b want 1", dmem_req); end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    tick();
    dmem_ack = 1'b0;
    total++; if (done !== 1'b1 || error !== 1'b0 || load_data !== 32'h1234_5678)
      begin bad++; $display("FAIL ackto_win got done=%b err=%b ld=%h want 1 0 12345678", done, error, load_data); end
    tick();
  endtask

  task automatic test_illegal();
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0400, 32'd0);
    total++; if (done !== 1'b1 || error !== 1'b1 || dmem_req !== 1'b0 || busy !== 1'b1 || load_data !== 32'h1234_5678)
      begin bad++; $display("FAIL illegal_ld got done=%b err=%b req=%b busy=%b ld=%h want 1 1 0 1 12345678",
                            done, error, dmem_req, busy, load_data); end
    tick();
    issue(1'b0, 1'b1, 3'b100, 32'h0000_0400, 32'h55);
    total++; if (done !== 1'b1 || error !== 1'b1 || dmem_req !== 1'b0)
      begin bad++; $display("FAIL illegal_sbu got done=%b err=%b req=%b want 1 1 0", done, error, dmem_req); end
    tick();
    total++; if (error !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL illegal_clear got err=%b done=%b busy=%b want 0 0 0", error, done, busy); end
  endtask

  task automatic test_nonmem();
    issue(1'b0, 1'b0, 3'b011, 32'h0000_0600, 32'd0);
    total++; if (done !== 1'b1 || error !== 1'b0 || dmem_req !== 1'b0 || load_data !== 32'h1234_5678)
      begin bad++; $display("FAIL nonmem got done=%b err=%b req=%b ld=%h want 1 0 0 12345678",
                            done, error, dmem_req, load_data); end
    tick();
    total++; if (busy !== 1'b0)
      begin bad++; $display("FAIL nonmem_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0);
`ifdef MISALIGN_CHECK_EN
    total++; if (dmem_req !== 1'b0 || done !== 1'b1 || misaligned !== 1'b1 || load_data !== 32'd0 || error !== 1'b0)
      begin bad++; $display("FAIL misalign_w got req=%b done=%b mis=%b ld=%h err=%b want 0 1 1 00000000 0",
                            dmem_req, done, misaligned, load_data, error); end
    tick();
`else
    total++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0100 || dmem_be !== 4'b1111)
      begin bad++; $display("FAIL misalign_w got req=%b a=%h be=%b want 1 00000100 1111", dmem_req, dmem_addr, dmem_be); end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 1'b0;
    total++; if (done !== 1'b1 || misaligned !== 1'b0 || load_data !== 32'hCAFE_F00D)
      begin bad++; $display("FAIL misalign_w_done got done=%b mis=%b ld=%h want 1 0 cafef00d", done, misaligned, load_data); end
    tick();
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0203, 32'd0);
    total++; if (dmem_be !== 4'b1100 || dmem_addr !== 32'h0000_0200)
      begin bad++; $display("FAIL lh_odd_be got be=%b a=%h want 1100 00000200", dmem_be, dmem_addr); end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h8001_7FFF;
    tick();
    dmem_ack = 1'b0;
    total++; if (load_data !== 32'hFFFF_8001)
      begin bad++; $display("FAIL lh_odd_data got %h want ffff8001", load_data); end
    tick();
`endif
  endtask

  task automatic test_ack_idle();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BAD_0BAD;
    tick();
    tick();
    dmem_ack = 1'b0;
    total++; if (done !== 1'b0 || busy !== 1'b0 || load_data === 32'h0BAD_0BAD)
      begin bad++; $display("FAIL ack_idle got done=%b busy=%b ld=%h want 0 0 not 0bad0bad", done, busy, load_data); end
  endtask

  task automatic test_reset_in_req();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'd0);
    tick();
    // second REQ cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h7777_7777;
    total++; if (dmem_req !== 1'b0 || busy !== 1'b0 || load_data !== 32'd0 || dmem_addr !== 32'd0)
      begin bad++; $display("FAIL rst_req_drop got req=%b busy=%b ld=%h a=%h want 0 0 00000000 00000000",
                            dmem_req, busy, load_data, dmem_addr); end
    tick();
    dmem_ack = 1'b0;
    total++; if (done !== 1'b0 || busy !== 1'b0 || load_data !== 32'd0 || error !== 1'b0 || dmem_req !== 1'b0)
      begin bad++; $display("FAIL rst_late_ack got done=%b busy=%b ld=%h err=%b req=%b want 0 0 00000000 0 0",
                            done, busy, load_data, error, dmem_req); end
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    alu_result = 32'd0;
    store_data = 32'd0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    funct3 = 3'b000;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_timeout();
    test_ack_at_timeout();
    test_illegal();
    test_nonmem();
    test_misalign();
    test_ack_idle();
    test_reset_in_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_memory.md
STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 Parameter TIMEOUT, default 16; the maximum number of cycles a request may wait for dmem_ack before it is abandoned (range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  execute stage presents a valid operation this cycle.
REQ-005 alu_result  input  32  byte address from execute.
REQ-006 store_data  input  32  register rs2 data for stores.
REQ-007 mem_read / mem_write  input  1 each  operation type; neither set = non-memory instruction.
REQ-008 funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 dmem_req, dmem_we  output  1 each  memory request and write enable.
REQ-010 dmem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-011 dmem_wdata  output  32; dmem_be  output  4  write data and byte enables.
REQ-012 dmem_ack  input  1; dmem_rdata  input  32  memory response.
REQ-013 busy  output  1  pipeline stall; done  output  1  one-cycle completion pulse.
REQ-014 load_data  output  32  extended load result; error  output  1  illegal funct3 or timeout; misaligned  output  1.

Function
REQ-015 FSM states: IDLE, REQ, DONE; busy SHALL be 1 in REQ and DONE, and 0 in IDLE.
REQ-016 In IDLE with start=1, the block SHALL latch address, store_data, funct3, and operation type.
REQ-017 It SHALL then go to REQ for a load or store, and to DONE for a non-memory or rejected operation.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 In REQ, dmem_req SHALL be held at 1, with stable addr, we, be, and wdata, until the cycle dmem_ack=1.
REQ-020 On dmem_ack in REQ, the block SHALL go to DONE, and for a load capture the extended dmem_rdata into load_data.
REQ-021 Latency: start at cycle N, dmem_req from N+1, ack at cycle N+1+k (k>=0), done=1 at N+2+k, IDLE at N+3+k.
REQ-022 The wait counter SHALL clear on entry to REQ and increment per REQ cycle without ack.
REQ-023 When the counter reaches TIMEOUT, the block SHALL drop dmem_req, go to DONE, set load_data=0 and assert error with done.
REQ-024 If ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win and no error is raised.
REQ-025 Byte enables: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<{addr[1],1'b0}; W -> 4'b1111.
REQ-026 Store data: B replicates the byte four times, H replicates the halfword twice, W passes straight through; loads drive dmem_we=0.
REQ-027 Loads SHALL select the lane by addr[1:0], sign-extend for B/H and zero-extend for BU/HU.
REQ-028 Illegal funct3 (011, 110, 111, and BU/HU on a store) SHALL issue no request and assert error with done.
REQ-029 Non-memory start SHALL produce done after one cycle with load_data unchanged and error=0.
REQ-030 done, error, and misaligned SHALL be registered and valid only in the DONE cycle; otherwise 0.
REQ-031 dmem_ack outside REQ SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE and zero every output: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, busy, done, load_data, error, and misaligned.
REQ-033 Reset during REQ SHALL drop dmem_req on the next edge; any ack returned after reset SHALL be ignored.
REQ-034 Reset SHALL take priority over start and dmem_ack in the same cycle.

Configuration
REQ-035 Macro MISALIGN_CHECK_EN, when defined, SHALL flag H/HU at odd addresses and W at addr[1:0]!=0 as misaligned.
REQ-036 A flagged access SHALL issue no request and go straight to DONE with misaligned=1 and load_data=0.
REQ-037 Without MISALIGN_CHECK_EN, misaligned SHALL be tied 0.
REQ-038 Without MISALIGN_CHECK_EN, W SHALL ignore addr[1:0] and H/HU SHALL ignore addr[0].

Verification
REQ-039 LW at 0x100, ack on the first REQ cycle, rdata 0xDEADBEEF -> dmem_addr=0x100, be=1111, done at N+2, load_data=0xDEADBEEF.
REQ-040 LB at 0x103 and LBU at 0x103, rdata 0x80112233 -> load_data=0xFFFFFF80 for LB and 0x00000080 for LBU.
REQ-041 SH at 0x202 with store_data 0x0000ABCD, ack after 3 cycles -> wdata=0xABCDABCD, be=1100, we=1, busy for 5 cycles, done at N+5.
REQ-042 LW with ack never arriving, TIMEOUT=16 -> dmem_req high 16 cycles then low, done=1, error=1, load_data=0.
REQ-043 Reset asserted on the second REQ cycle, then ack one cycle later -> dmem_req=0 after the edge, no done, all outputs 0.
REQ-044 With MISALIGN_CHECK_EN, LW at 0x101 -> no dmem_req, done and misaligned at N+1; without the macro -> request to 0x100, misaligned=0.
